// File: rtl/dmem_arbiter_mc.sv
// Shared data-memory front end for the multicore accumulator build: round-robin
// arbitration of per-core memory requests plus a start/done run sequencer.
module dmem_arbiter_mc #(
   parameter int CORES      = 4,
   parameter int REG_WIDTH  = 12,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                        clk,
   input  logic                        rstN,
   input  logic                        start,
   output logic                        ready,
   output logic                        all_done,
   output logic                        core_start,
   input  logic [CORES-1:0]            core_done,
   input  logic [CORES-1:0]            req,
   input  logic [CORES-1:0]            we,
   input  logic [CORES*ADDR_WIDTH-1:0] addr,
   input  logic [CORES*REG_WIDTH-1:0]  wdata,
   output logic [CORES-1:0]            gnt,
   output logic [CORES-1:0]            rvalid,
   output logic [REG_WIDTH-1:0]        rdata,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [REG_WIDTH-1:0]        mem_wdata,
   output logic                        mem_we,
   input  logic [REG_WIDTH-1:0]        mem_rdata
);

   localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    win;
   logic [PW-1:0]    scan_idx;
   logic             found;
   logic [CORES-1:0] done_q;

   // First requester at or after the pointer, wrapping around, wins the cycle.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      scan_idx = '0;
      for (int i = 0; i < CORES; i++) begin
         scan_idx = PW'((int'(ptr) + i) % CORES);
         if (!found && req[scan_idx]) begin
            found = 1'b1;
            win   = scan_idx;
         end
      end
   end

   always_comb begin
      gnt       = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (found) begin
         gnt[win]  = 1'b1;
         mem_addr  = addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
         mem_wdata = wdata[int'(win)*REG_WIDTH +: REG_WIDTH];
         mem_we    = we[win];
      end
   end

   assign rdata = mem_rdata;

   // The memory answers one cycle after the address, so the read strobe is the delayed grant.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ptr    <= '0;
         rvalid <= '0;
      end else begin
         if (found) begin
            ptr <= PW'((int'(win) + 1) % CORES);
         end
         if (found && !we[win]) begin
            rvalid <= gnt;
         end else begin
            rvalid <= '0;
         end
      end
   end

   // Run sequencer; clearing the sticky bits on an accepted start overrides any done seen that edge.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state      <= IDLE;
         done_q     <= '0;
         ready      <= 1'b1;
         all_done   <= 1'b0;
         core_start <= 1'b0;
      end else begin
         core_start <= 1'b0;
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  state      <= RUN;
                  done_q     <= '0;
                  core_start <= 1'b1;
                  ready      <= 1'b0;
                  all_done   <= 1'b0;
               end
            end
            RUN: begin
               done_q <= done_q | core_done;
               if (&done_q) begin
                  state    <= FIN;
                  ready    <= 1'b1;
                  all_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter_mc.sv
// Directed and randomized bench for dmem_arbiter_mc against a behavioural model
// of round-robin service, a shadow data memory and the start/done run rules.
module tb_dmem_arbiter_mc;

   localparam int CORES = 4;
   localparam int RW    = 12;
   localparam int AW    = 12;

   logic                 clk;
   logic                 rstN;
   logic                 start;
   logic                 ready;
   logic                 all_done;
   logic                 core_start;
   logic [CORES-1:0]     core_done;
   logic [CORES-1:0]     req;
   logic [CORES-1:0]     we;
   logic [CORES*AW-1:0]  addr;
   logic [CORES*RW-1:0]  wdata;
   logic [CORES-1:0]     gnt;
   logic [CORES-1:0]     rvalid;
   logic [RW-1:0]        rdata;
   logic [AW-1:0]        mem_addr;
   logic [RW-1:0]        mem_wdata;
   logic                 mem_we;
   logic [RW-1:0]        mem_rdata;

   dmem_arbiter_mc #(.CORES(CORES), .REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstN(rstN), .start(start), .ready(ready), .all_done(all_done),
      .core_start(core_start), .core_done(core_done), .req(req), .we(we),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous data memory with one-cycle read latency.
   logic [RW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   int            checks;
   int            failures;
   int            ref_ptr;
   logic [RW-1:0] ref_mem [0:(1<<AW)-1];
   logic [CORES-1:0] exp_rvalid;
   logic [RW-1:0] exp_rdata;
   bit            running;
   bit            finished;
   bit            seen [CORES];
   bit            exp_core_start;

   logic [CORES-1:0] last_gnt;
   logic             last_mem_we;
   logic [CORES-1:0] last_rvalid;
   logic [RW-1:0]    last_rdata;
   logic             last_core_start;
   logic             last_all_done;
   logic             last_ready;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_core(input int c, input logic [AW-1:0] a, input logic [RW-1:0] d);
      addr[c*AW +: AW]  = a;
      wdata[c*RW +: RW] = d;
   endtask

   function automatic int winner();
      for (int i = 0; i < CORES; i++) begin
         int c;
         c = (ref_ptr + i) % CORES;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      ref_ptr    = 0;
      exp_rvalid = '0;
      running    = 1'b0;
      finished   = 1'b0;
      for (int i = 0; i < CORES; i++) seen[i] = 1'b0;
   endtask

   // Inputs are set at a falling edge; one clock of DUT vs model, returning at the next falling edge.
   task automatic apply_stimulus();
      int            w;
      logic [AW-1:0] a;
      logic [RW-1:0] d;
      bit            all_seen;
      bit            was_running;
      a = '0;
      d = '0;
      #3;
      w = winner();
      last_gnt    = gnt;
      last_mem_we = mem_we;
      if (w < 0) begin
         check_output("gnt_none", 32'(gnt), 32'd0);
         check_output("mem_we_none", 32'(mem_we), 32'd0);
         check_output("mem_addr_none", 32'(mem_addr), 32'd0);
         check_output("mem_wdata_none", 32'(mem_wdata), 32'd0);
      end else begin
         a = addr[w*AW +: AW];
         d = wdata[w*RW +: RW];
         check_output("gnt", 32'(gnt), 32'(1 << w));
         check_output("mem_we", 32'(mem_we), 32'(we[w]));
         check_output("mem_addr", 32'(mem_addr), 32'(a));
         check_output("mem_wdata", 32'(mem_wdata), 32'(d));
      end
      @(posedge clk);
      exp_rvalid = '0;
      if (w >= 0) begin
         if (we[w]) ref_mem[a] = d;
         else begin
            exp_rvalid[w] = 1'b1;
            exp_rdata     = ref_mem[a];
         end
         ref_ptr = (w + 1) % CORES;
      end
      was_running    = running;
      exp_core_start = 1'b0;
      if (was_running) begin
         all_seen = 1'b1;
         for (int i = 0; i < CORES; i++) if (!seen[i]) all_seen = 1'b0;
         if (all_seen) begin
            running  = 1'b0;
            finished = 1'b1;
         end else begin
            for (int i = 0; i < CORES; i++) if (core_done[i]) seen[i] = 1'b1;
         end
      end else if (start) begin
         exp_core_start = 1'b1;
         running        = 1'b1;
         finished       = 1'b0;
         for (int i = 0; i < CORES; i++) seen[i] = 1'b0;
      end
      #1;
      last_rvalid     = rvalid;
      last_rdata      = rdata;
      last_core_start = core_start;
      last_all_done   = all_done;
      last_ready      = ready;
      check_output("rvalid", 32'(rvalid), 32'(exp_rvalid));
      if (exp_rvalid != '0) check_output("rdata", 32'(rdata), 32'(exp_rdata));
      check_output("ready", 32'(ready), 32'(!running));
      check_output("all_done", 32'(all_done), 32'(finished));
      check_output("core_start", 32'(core_start), 32'(exp_core_start));
      @(negedge clk);
   endtask

   logic [CORES-1:0] sat_exp [8];

   initial begin
      checks    = 0;
      failures  = 0;
      sat_exp   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < (1<<AW); i++) begin
         mem[i]     = RW'($urandom);
         ref_mem[i] = mem[i];
      end
      rstN      = 1'b1;
      start     = 1'b0;
      core_done = '0;
      req       = '0;
      we        = '0;
      addr      = '0;
      wdata     = '0;
      model_reset();
      #2 rstN = 1'b0;
      #1;
      check_output("reset_ready", 32'(ready), 32'd1);
      check_output("reset_all_done", 32'(all_done), 32'd0);
      check_output("reset_core_start", 32'(core_start), 32'd0);
      check_output("reset_rvalid", 32'(rvalid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;

      // Start a run and a read together, then reset while both outputs are high.
      req = 4'b0001; we = 4'b0000; start = 1'b1;
      set_core(0, 12'h003, 12'h000);
      apply_stimulus();
      check_output("pre_rst_core_start", 32'(last_core_start), 32'd1);
      check_output("pre_rst_rvalid", 32'(last_rvalid), 32'b0001);
      rstN = 1'b0;
      #1;
      check_output("midrst_ready", 32'(ready), 32'd1);
      check_output("midrst_all_done", 32'(all_done), 32'd0);
      check_output("midrst_rvalid", 32'(rvalid), 32'd0);
      check_output("midrst_core_start", 32'(core_start), 32'd0);
      model_reset();
      req = '0; start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;

      req = 4'b1111;
      for (int i = 0; i < CORES; i++) set_core(i, AW'(16 + i), RW'(i));
      apply_stimulus();
      check_output("post_rst_gnt", 32'(last_gnt), 32'b0001);
      for (int k = 0; k < 8; k++) begin
         apply_stimulus();
         check_output("sat_gnt", 32'(last_gnt), 32'(sat_exp[k]));
      end

      req = 4'b1001;
      apply_stimulus();
      check_output("skip_gnt_a", 32'(last_gnt), 32'b1000);
      apply_stimulus();
      check_output("skip_gnt_b", 32'(last_gnt), 32'b0001);

      req = 4'b0100; we = 4'b0100;
      set_core(2, 12'h010, 12'hA5C);
      apply_stimulus();
      check_output("wr_mem_we", 32'(last_mem_we), 32'd1);
      we = 4'b0000;
      apply_stimulus();
      check_output("rd_rvalid", 32'(last_rvalid), 32'b0100);
      check_output("rd_rdata", 32'(last_rdata), 32'hA5C);
      req = '0;

      start = 1'b1;
      apply_stimulus();
      check_output("run_core_start", 32'(last_core_start), 32'd1);
      start = 1'b0;
      apply_stimulus();
      check_output("run_pulse_single", 32'(last_core_start), 32'd0);
      core_done = 4'b1000; apply_stimulus();
      core_done = 4'b0001; start = 1'b1; apply_stimulus();
      check_output("start_in_run", 32'(last_core_start), 32'd0);
      start = 1'b0;
      core_done = 4'b0100; apply_stimulus();
      core_done = 4'b0010; apply_stimulus();
      check_output("run_not_done_yet", 32'(last_all_done), 32'd0);
      core_done = 4'b0000; apply_stimulus();
      check_output("run_all_done", 32'(last_all_done), 32'd1);
      check_output("run_ready", 32'(last_ready), 32'd1);

      start = 1'b1; core_done = 4'b0001;
      apply_stimulus();
      check_output("restart_core_start", 32'(last_core_start), 32'd1);
      check_output("restart_all_done", 32'(last_all_done), 32'd0);
      start = 1'b0;
      core_done = 4'b0010; apply_stimulus();
      core_done = 4'b0100; apply_stimulus();
      core_done = 4'b1000; apply_stimulus();
      core_done = 4'b0000; apply_stimulus();
      apply_stimulus();
      check_output("restart_cleared", 32'(last_all_done), 32'd0);
      core_done = 4'b0001; apply_stimulus();
      core_done = 4'b0000; apply_stimulus();
      check_output("restart_all_done_again", 32'(last_all_done), 32'd1);

      for (int n = 0; n < 400; n++) begin
         req   = CORES'($urandom);
         we    = CORES'($urandom);
         start = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < CORES; i++) begin
            core_done[i] = ($urandom_range(0, 5) == 0);
            set_core(i, AW'($urandom_range(0, 15)), RW'($urandom));
         end
         apply_stimulus();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
